// File: rtl/divider_top_if.sv
// Operand/result bundle shared by the divider and its front end.
// The front end drives operands and valid; the divider returns status and results.
interface divider_top_if #(
    parameter int unsigned N_WIDTH = 16,
    parameter int unsigned D_WIDTH = 8
);
    logic               valid;
    logic [N_WIDTH-1:0] dividend;
    logic               dividend_sign;
    logic [D_WIDTH-1:0] divisor;
    logic               divisor_sign;
    logic               busy;
    logic               div_done;
    logic               div_by_zero;
    logic               div_sign;
    logic [N_WIDTH-1:0] quotient;
    logic [D_WIDTH-1:0] remainder;

    modport master (
        output valid, dividend, dividend_sign, divisor, divisor_sign,
        input  busy, div_done, div_by_zero, div_sign, quotient, remainder
    );

    modport slave (
        input  valid, dividend, dividend_sign, divisor, divisor_sign,
        output busy, div_done, div_by_zero, div_sign, quotient, remainder
    );
endinterface

// File: rtl/divider_top.sv
// Sequential sign-magnitude restoring divider, one quotient bit per clock.
// Results are held in output registers until the next completion.
module divider_top #(
    parameter int unsigned N_WIDTH = 16,
    parameter int unsigned D_WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    divider_top_if.slave bus
);
    localparam int unsigned CntW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [N_WIDTH-1:0] dvd_q, dvd_d;
    logic [D_WIDTH-1:0] dvs_q, dvs_d;
    logic [D_WIDTH:0]   rem_q, rem_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [N_WIDTH-1:0] quotient_q, quotient_d;
    logic [D_WIDTH-1:0] remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic               div_sign_q, div_sign_d;

    logic [D_WIDTH:0]   rem_shift;
    logic [D_WIDTH+1:0] trial;
    logic               q_bit;
    logic [D_WIDTH:0]   rem_next;
    logic [N_WIDTH-1:0] quo_next;

    // Dividend register doubles as the quotient: bits leave at the MSB, quotient bits enter at LSB.
    always_comb begin
        rem_shift = {rem_q[D_WIDTH-1:0], dvd_q[N_WIDTH-1]};
        trial     = {1'b0, rem_shift} - {2'b00, dvs_q};
        q_bit     = ~trial[D_WIDTH+1];
        rem_next  = q_bit ? trial[D_WIDTH:0] : rem_shift;
        quo_next  = {dvd_q[N_WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        div_sign_d  = div_sign_q;
        case (state_q)
            StIdle: begin
                if (bus.valid) begin
                    if (bus.divisor != '0) begin
                        dvd_d   = bus.dividend;
                        dvs_d   = bus.divisor;
                        sign_d  = bus.dividend_sign ^ bus.divisor_sign;
                        rem_d   = '0;
                        cnt_d   = CntW'(N_WIDTH - 1);
                        state_d = StCalc;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                        div_sign_d  = 1'b0;
                        state_d     = StDone;
                    end
                end
            end
            StCalc: begin
                dvd_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    quotient_d  = quo_next;
                    remainder_d = rem_next[D_WIDTH-1:0];
                    dbz_d       = 1'b0;
                    // A zero quotient is never reported as negative.
                    div_sign_d  = sign_q & (|quo_next);
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (!bus.valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            div_sign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            div_sign_q  <= div_sign_d;
        end
    end

    assign bus.busy        = (state_q == StCalc);
    assign bus.div_done    = (state_q == StDone);
    assign bus.div_by_zero = dbz_q;
    assign bus.div_sign    = div_sign_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
endmodule

// File: tb/tb_divider_top.sv
// Directed and randomized checks of divider_top against hand-computed results.
module tb_divider_top;
    localparam int unsigned N_WIDTH = 16;
    localparam int unsigned D_WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    divider_top_if #(.N_WIDTH(N_WIDTH), .D_WIDTH(D_WIDTH)) bus ();

    divider_top #(.N_WIDTH(N_WIDTH), .D_WIDTH(D_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Presents operands with valid high, then waits (bounded) for div_done; valid stays high.
    task automatic run_op(input logic [15:0] a, input logic as, input logic [7:0] b,
                          input logic bs, output int lat, output int busy_cnt);
        bus.dividend      = a;
        bus.dividend_sign = as;
        bus.divisor       = b;
        bus.divisor_sign  = bs;
        bus.valid         = 1'b1;
        @(posedge clk); #1;
        lat      = 0;
        busy_cnt = 0;
        while (!bus.div_done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", bus.div_done, 1);
    endtask

    task automatic drop_valid();
        bus.valid = 1'b0;
        @(posedge clk); #1;
        check("done_fall", bus.div_done, 0);
    endtask

    task automatic expect_res(input string tag, input logic [15:0] q, input logic [7:0] r,
                              input logic s, input logic z);
        check({tag, "_q"}, bus.quotient, q);
        check({tag, "_r"}, bus.remainder, r);
        check({tag, "_s"}, bus.div_sign, s);
        check({tag, "_z"}, bus.div_by_zero, z);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.div_done, 0);
        expect_res(tag, 16'd0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int lat, bcnt;
        logic [15:0] a, eq;
        logic [7:0]  b, er;
        logic        as, bs;

        rst               = 1'b1;
        bus.valid         = 1'b0;
        bus.dividend      = '0;
        bus.dividend_sign = 1'b0;
        bus.divisor       = '0;
        bus.divisor_sign  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 12 / 4: 16 busy cycles, done on the 17th edge counting the accept edge
        run_op(16'd12, 1'b0, 8'd4, 1'b0, lat, bcnt);
        check("lat_12_4", lat, 16);
        check("busy_12_4", bcnt, 16);
        expect_res("d12_4", 16'd3, 8'd0, 1'b0, 1'b0);
        drop_valid();

        // -30 / 7
        run_op(16'd30, 1'b1, 8'd7, 1'b0, lat, bcnt);
        expect_res("d30_7", 16'd4, 8'd2, 1'b1, 1'b0);
        drop_valid();
        expect_res("hold30_7", 16'd4, 8'd2, 1'b1, 1'b0);
        check("idle_busy", bus.busy, 0);

        run_op(16'd65535, 1'b0, 8'd1, 1'b0, lat, bcnt);
        expect_res("d65535_1", 16'd65535, 8'd0, 1'b0, 1'b0);
        drop_valid();
        run_op(16'd65535, 1'b0, 8'd255, 1'b1, lat, bcnt);
        expect_res("d65535_255", 16'd257, 8'd0, 1'b1, 1'b0);
        drop_valid();
        run_op(16'd5, 1'b1, 8'd9, 1'b0, lat, bcnt);
        expect_res("d5_9", 16'd0, 8'd5, 1'b0, 1'b0);
        drop_valid();
        run_op(16'd0, 1'b1, 8'd13, 1'b0, lat, bcnt);
        expect_res("d0_13", 16'd0, 8'd0, 1'b0, 1'b0);
        drop_valid();

        // Divide by zero: done straight after the accept edge, never busy
        run_op(16'd100, 1'b1, 8'd0, 1'b0, lat, bcnt);
        check("lat_dbz", lat, 0);
        check("busy_dbz", bcnt, 0);
        expect_res("dbz", 16'hFFFF, 8'd0, 1'b0, 1'b1);
        drop_valid();

        // Async reset part-way through CALC
        bus.dividend      = 16'd200;
        bus.dividend_sign = 1'b0;
        bus.divisor       = 8'd3;
        bus.divisor_sign  = 1'b0;
        bus.valid         = 1'b1;
        @(posedge clk); #1;
        repeat (8) @(posedge clk);
        #2;
        check("pre_rst_busy", bus.busy, 1);
        bus.valid = 1'b0;
        rst       = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(16'd200, 1'b0, 8'd3, 1'b0, lat, bcnt);
        expect_res("d200_3", 16'd66, 8'd2, 1'b0, 1'b0);
        drop_valid();

        // Operands change mid-CALC; valid held through DONE
        bus.dividend      = 16'd1000;
        bus.dividend_sign = 1'b0;
        bus.divisor       = 8'd10;
        bus.divisor_sign  = 1'b1;
        bus.valid         = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        bus.dividend     = 16'd7;
        bus.divisor      = 8'd2;
        bus.divisor_sign = 1'b0;
        lat = 0;
        while (!bus.div_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lock_lat", lat, 11);
        expect_res("lock", 16'd100, 8'd0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("lock_hold_done", bus.div_done, 1);
        check("lock_hold_busy", bus.busy, 0);
        expect_res("lock_hold", 16'd100, 8'd0, 1'b1, 1'b0);
        drop_valid();

        // Random sweep against a reference division
        for (int i = 0; i < 1000; i++) begin
            a  = 16'($urandom_range(0, 65535));
            b  = 8'($urandom_range(1, 255));
            as = 1'($urandom_range(0, 1));
            bs = 1'($urandom_range(0, 1));
            eq = a / b;
            er = 8'(a % b);
            run_op(a, as, b, bs, lat, bcnt);
            check("rnd_q", bus.quotient, eq);
            check("rnd_r", bus.remainder, er);
            check("rnd_rlt", bus.remainder < b, 1);
            check("rnd_s", bus.div_sign, (as ^ bs) && (eq != 0));
            bus.valid = 1'b0;
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/divider_top.md
Name: divider_top

Overview:
- Sequential sign-magnitude restoring divider. It is the inverse companion to the multiplier datapath and consumes products in the same format: a 16-bit magnitude plus a separate sign bit.
- It computes quotient and remainder one bit per clock.
- It uses the same valid/done operand handshake as the multiplier, so the two blocks can sit side by side behind one operand front end.

Parameters:
- N_WIDTH, 16, dividend and quotient magnitude width.
- D_WIDTH, 8, divisor and remainder magnitude width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid  input  1  operands valid; level request, held high until div_done is seen.
- dividend  input  N_WIDTH  dividend magnitude.
- dividend_sign  input  1  dividend sign (1 = negative).
- divisor  input  D_WIDTH  divisor magnitude.
- divisor_sign  input  1  divisor sign.
- busy  output  1  high in CALC.
- div_done  output  1  result valid; high in DONE.
- div_by_zero  output  1  last operation had divisor == 0.
- div_sign  output  1  quotient sign.
- quotient  output  N_WIDTH  quotient magnitude.
- remainder  output  D_WIDTH  remainder magnitude (remainder sign is implicitly dividend_sign).

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal registers 0. Reset mid-CALC aborts the operation with no partial result exposed.
- State IDLE:
  - valid=1 and divisor!=0: latch dividend, divisor and signs; clear partial remainder; iteration counter=N_WIDTH-1; go to CALC.
  - valid=1 and divisor==0: go to DONE with quotient=all ones, remainder=0, div_by_zero=1, div_sign=0.
  - valid=0: stay in IDLE; outputs hold their previous result.
- State CALC, one restoring step per cycle:
  - Shift the partial remainder (D_WIDTH+1 bits) left, bringing in the dividend MSB.
  - Trial-subtract the divisor.
  - If the trial is non-negative, keep the difference and shift quotient bit 1; otherwise restore and shift 0.
  - The counter decrements; when the counter==0 step completes, go to DONE.
- Operand lock: operand inputs are ignored after the accept edge; changes during CALC have no effect.
- Entering DONE from CALC, the output registers update:
  - quotient and remainder take the final values.
  - div_by_zero=0.
  - div_sign = dividend_sign XOR divisor_sign, forced 0 when quotient==0.
- Latency: accept edge at cycle 0; div_done high after edge N_WIDTH+1, i.e. 17 cycles for the default. Divide-by-zero: div_done high after edge 1.
- State DONE:
  - div_done=1; outputs stable.
  - Stays in DONE while valid=1 (4-phase handshake, no retrigger while valid is held).
  - valid=0: go to IDLE, div_done=0; results persist until the next completion.
- Outputs: all outputs are registered; none are combinational from inputs.
- Width rules: remainder < divisor always; quotient*divisor+remainder == dividend (magnitudes) for every divisor != 0.
- Boundaries:
  - dividend=0 gives quotient=0, remainder=0, div_sign=0.
  - divisor=1 gives quotient=dividend.
  - dividend < divisor gives quotient=0, remainder=dividend[D_WIDTH-1:0].
- Simultaneous events: rst has priority over everything; a valid edge in the same cycle as DONE->IDLE is not accepted until the next IDLE cycle.

Test Plan:
- Reset, then valid with 12 / 4, both signs 0 -> busy high for 16 cycles; div_done at cycle 17; quotient=3, remainder=0, div_sign=0.
- 30 / 7 with dividend_sign=1, divisor_sign=0 -> quotient=4, remainder=2, div_sign=1. Drop valid -> div_done falls the next cycle and outputs hold.
- 65535 / 1, then 65535 / 255, then 5 / 9 -> (65535, 0), (257, 0), (0, 5) with div_sign=0 on the last.
- Divisor=0, dividend=100 -> div_done after one cycle; div_by_zero=1, quotient=16'hFFFF, remainder=0, busy never asserted.
- Assert rst at cycle 8 of CALC for 200 / 3 -> all outputs 0 immediately (async). A following 200 / 3 -> quotient=66, remainder=2.
- Change operands mid-CALC and hold valid high through DONE -> result matches the latched operands and no second operation starts until valid falls.
- Random sweep of 1000 operand pairs (divisor != 0) -> quotient*divisor+remainder==dividend and remainder<divisor on every result.
